// File: rtl/quant_pkg.sv
// Shared definitions for the quantizer back end: header field layout, beat width,
// packer state encoding. PACKER_CHECKSUM_EN adds the TRAILER state.
package quant_pkg;

  localparam int unsigned BEAT_WIDTH     = 64;
  localparam int unsigned MAX_VALID_BITS = 496;

  localparam int unsigned HDR_MASK_LSB = 0;
  localparam int unsigned HDR_MASK_W   = 16;
  localparam int unsigned HDR_NVB_LSB  = 16;
  localparam int unsigned HDR_NVB_W    = 9;
  localparam int unsigned HDR_K_LSB    = 25;
  localparam int unsigned HDR_K_W      = 5;
  localparam int unsigned HDR_P_LSB    = 30;
  localparam int unsigned HDR_P_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_OUTLIER
`ifdef PACKER_CHECKSUM_EN
    , ST_TRAILER
`endif
  } packState_t;

  function automatic logic [4:0] popCount16(input logic [15:0] m);
    logic [4:0] c;
    c = '0;
    for (int unsigned i = 0; i < 16; i++) c = c + 5'(m[i]);
    return c;
  endfunction

endpackage

// File: rtl/outlier_pick.sv
// Finds the lowest and second-lowest set bit positions of a 16-bit mask.
module outlier_pick (
  input  logic [15:0] mask,
  output logic [3:0]  firstIdx,
  output logic [3:0]  secondIdx,
  output logic        firstFound,
  output logic        secondFound
);

  always_comb begin
    firstIdx    = '0;
    secondIdx   = '0;
    firstFound  = 1'b0;
    secondFound = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (mask[i]) begin
        if (!firstFound) begin
          firstFound = 1'b1;
          firstIdx   = 4'(i);
        end else if (!secondFound) begin
          secondFound = 1'b1;
          secondIdx   = 4'(i);
        end
      end
    end
  end

endmodule

// File: rtl/quant_block_packer.sv
// Serialises one quantized block as header, payload beats, outlier word pairs.
// Define PACKER_CHECKSUM_EN to append an XOR trailer beat carrying OutLast.
module quant_block_packer
  import quant_pkg::*;
#(
  parameter int unsigned L2_WIDTH        = 512,
  parameter int unsigned WordWidth_WIDTH = 32,
  parameter int unsigned NumOfWordsinBlk = 16,
  parameter int unsigned BEAT_WIDTH      = quant_pkg::BEAT_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       InBlkValid,
  output logic                                       InBlkReady,
  input  logic [L2_WIDTH-1:0]                        QuantStr,
  input  logic [$clog2(MAX_VALID_BITS+1)-1:0]        NumValidBits,
  input  logic [NumOfWordsinBlk-1:0]                 IsOutlierArray,
  input  logic [NumOfWordsinBlk*WordWidth_WIDTH-1:0] InputWords,
  output logic [BEAT_WIDTH-1:0]                      OutBeat,
  output logic                                       OutValid,
  input  logic                                       OutReady,
  output logic                                       OutLast
);

  packState_t state, nextState;

  logic [L2_WIDTH-1:0]                        quantReg;
  logic [8:0]                                 nvbReg;
  logic [15:0]                                maskReg, workMask, clrMask;
  logic [NumOfWordsinBlk*WordWidth_WIDTH-1:0] wordsReg;
  logic [4:0]                                 kReg, kIn;
  logic [3:0]                                 pReg, kBeats;
  logic [2:0]                                 payIdx;
  logic [3:0]                                 outCnt;
  logic [9:0]                                 pSum, bitBase, remBits;
  logic [5:0]                                 kSum;
  logic                                       accept, hs, payLast, outLast, dataLast;
  logic [3:0]                                 firstIdx, secondIdx;
  logic                                       firstFound, secondFound;
  logic [BEAT_WIDTH-1:0]                      hdrBeat, payBeat, outBeatWord;
  logic [WordWidth_WIDTH-1:0]                 loWord, hiWord;
`ifdef PACKER_CHECKSUM_EN
  logic [BEAT_WIDTH-1:0]                      xorAcc;
  localparam packState_t DONE_STATE = ST_TRAILER;
`else
  localparam packState_t DONE_STATE = ST_IDLE;
`endif

  assign InBlkReady = (state == ST_IDLE) && !rst;
  assign accept     = InBlkValid && InBlkReady;
  assign hs         = OutValid && OutReady;

  assign kIn  = popCount16(IsOutlierArray);
  assign kSum = {1'b0, kIn} + 6'd1;
  assign pSum = {1'b0, NumValidBits} + 10'd63;

  outlier_pick uPick (
    .mask       (workMask),
    .firstIdx   (firstIdx),
    .secondIdx  (secondIdx),
    .firstFound (firstFound),
    .secondFound(secondFound)
  );

  always_comb begin
    hdrBeat = '0;
    hdrBeat[HDR_MASK_LSB +: HDR_MASK_W] = maskReg;
    hdrBeat[HDR_NVB_LSB  +: HDR_NVB_W]  = nvbReg;
    hdrBeat[HDR_K_LSB    +: HDR_K_W]    = kReg;
    hdrBeat[HDR_P_LSB    +: HDR_P_W]    = pReg;
  end

  // Bits past NumValidBits only ever fall inside the last payload beat.
  assign bitBase = {1'b0, payIdx, 6'd0};
  assign remBits = {1'b0, nvbReg} - bitBase;
  assign payBeat = quantReg[{payIdx, 6'd0} +: BEAT_WIDTH] &
                   ((remBits >= 10'd64) ? {BEAT_WIDTH{1'b1}} : ~({BEAT_WIDTH{1'b1}} << remBits[5:0]));

  assign loWord      = wordsReg[firstIdx*WordWidth_WIDTH +: WordWidth_WIDTH];
  assign hiWord      = secondFound ? wordsReg[secondIdx*WordWidth_WIDTH +: WordWidth_WIDTH] : '0;
  assign outBeatWord = {hiWord, loWord};
  assign clrMask     = (16'(firstFound) << firstIdx) | (16'(secondFound) << secondIdx);

  assign payLast = ({1'b0, payIdx} == (pReg - 4'd1));
  assign outLast = (outCnt == (kBeats - 4'd1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    OutValid  = 1'b0;
    OutBeat   = '0;
    dataLast  = 1'b0;
    case (state)
      ST_IDLE: if (accept) nextState = ST_HEADER;
      ST_HEADER: begin
        OutValid = 1'b1;
        OutBeat  = hdrBeat;
        dataLast = (pReg == 4'd0) && (kReg == 5'd0);
        if (OutReady)
          nextState = (pReg != 4'd0) ? ST_PAYLOAD : (kReg != 5'd0) ? ST_OUTLIER : DONE_STATE;
      end
      ST_PAYLOAD: begin
        OutValid = 1'b1;
        OutBeat  = payBeat;
        dataLast = payLast && (kReg == 5'd0);
        if (OutReady && payLast) nextState = (kReg != 5'd0) ? ST_OUTLIER : DONE_STATE;
      end
      ST_OUTLIER: begin
        OutValid = 1'b1;
        OutBeat  = outBeatWord;
        dataLast = outLast;
        if (OutReady && outLast) nextState = DONE_STATE;
      end
`ifdef PACKER_CHECKSUM_EN
      ST_TRAILER: begin
        OutValid = 1'b1;
        OutBeat  = xorAcc;
        if (OutReady) nextState = ST_IDLE;
      end
`endif
      default: nextState = ST_IDLE;
    endcase
  end

`ifdef PACKER_CHECKSUM_EN
  assign OutLast = (state == ST_TRAILER);
`else
  assign OutLast = dataLast;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      payIdx   <= '0;
      outCnt   <= '0;
      workMask <= '0;
`ifdef PACKER_CHECKSUM_EN
      xorAcc   <= '0;
`endif
    end else if (accept) begin
      quantReg <= QuantStr;
      nvbReg   <= NumValidBits;
      maskReg  <= IsOutlierArray;
      wordsReg <= InputWords;
      kReg     <= kIn;
      pReg     <= pSum[9:6];
      kBeats   <= kSum[4:1];
      workMask <= IsOutlierArray;
      payIdx   <= '0;
      outCnt   <= '0;
`ifdef PACKER_CHECKSUM_EN
      xorAcc   <= '0;
`endif
    end else if (hs) begin
      if (state == ST_PAYLOAD) payIdx <= payIdx + 3'd1;
      if (state == ST_OUTLIER) begin
        outCnt   <= outCnt + 4'd1;
        workMask <= workMask & ~clrMask;
      end
`ifdef PACKER_CHECKSUM_EN
      if (state != ST_TRAILER) xorAcc <= xorAcc ^ OutBeat;
`endif
    end
  end

endmodule

// File: tb/tb_quant_block_packer.sv
// Randomized bench for quant_block_packer against a beat-list reference model.
module tb_quant_block_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         InBlkValid;
  logic         InBlkReady;
  logic [511:0] QuantStr;
  logic [8:0]   NumValidBits;
  logic [15:0]  IsOutlierArray;
  logic [511:0] InputWords;
  logic [63:0]  OutBeat;
  logic         OutValid;
  logic         OutReady;
  logic         OutLast;

  int total = 0;
  int bad   = 0;
  logic [63:0] expQ[$];

  always #5 clk = ~clk;

  quant_block_packer dut (
    .clk           (clk),
    .rst           (rst),
    .InBlkValid    (InBlkValid),
    .InBlkReady    (InBlkReady),
    .QuantStr      (QuantStr),
    .NumValidBits  (NumValidBits),
    .IsOutlierArray(IsOutlierArray),
    .InputWords    (InputWords),
    .OutBeat       (OutBeat),
    .OutValid      (OutValid),
    .OutReady      (OutReady),
    .OutLast       (OutLast)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Expected beat list built straight from the block format description.
  task automatic buildModel(input logic [15:0] m, input int n, input logic [511:0] q,
                            input logic [511:0] w);
    int idxs[$];
    int p;
    logic [63:0] b;
    logic [63:0] acc;
    expQ.delete();
    for (int i = 0; i < 16; i++) if (m[i]) idxs.push_back(i);
    p = (n + 63) / 64;
    b = 64'(m) + (64'(n) << 16) + (64'(idxs.size()) << 25) + (64'(p) << 30);
    expQ.push_back(b);
    for (int j = 0; j < p; j++) begin
      b = '0;
      for (int t = 0; t < 64; t++) if (64 * j + t < n) b[t] = q[64 * j + t];
      expQ.push_back(b);
    end
    for (int i = 0; i < idxs.size(); i += 2) begin
      b = '0;
      b[31:0] = w[32 * idxs[i] +: 32];
      if (i + 1 < idxs.size()) b[63:32] = w[32 * idxs[i + 1] +: 32];
      expQ.push_back(b);
    end
`ifdef PACKER_CHECKSUM_EN
    acc = '0;
    foreach (expQ[i]) acc ^= expQ[i];
    expQ.push_back(acc);
`else
    acc = '0;
`endif
  endtask

  function automatic logic [511:0] randBits();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32 * i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic pickReady(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  task automatic runBlock(input logic [15:0] m, input int n, input logic [511:0] q,
                          input logic [511:0] w, input int mode);
    int idx;
    int cyc;
    logic stalled;
    logic [63:0] heldBeat;
    logic heldLast;
    buildModel(m, n, q, w);
    @(negedge clk);
    checkVal("idle_ready", 64'(InBlkReady), 64'd1);
    QuantStr       = q;
    NumValidBits   = 9'(n);
    IsOutlierArray = m;
    InputWords     = w;
    InBlkValid     = 1'b1;
    @(posedge clk);
    #1;
    InBlkValid     = 1'b0;
    QuantStr       = randBits();
    NumValidBits   = 9'($urandom_range(0, 496));
    IsOutlierArray = ~m;
    InputWords     = randBits();
    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    heldBeat = '0;
    heldLast = 1'b0;
    while (idx < expQ.size() && cyc < 400) begin
      OutReady = pickReady(mode, cyc);
      @(negedge clk);
      checkVal("busy_ready", 64'(InBlkReady), 64'd0);
      checkVal("out_valid", 64'(OutValid), 64'd1);
      if (!OutValid) break;
      if (stalled) begin
        checkVal("stall_beat", OutBeat, heldBeat);
        checkVal("stall_last", 64'(OutLast), 64'(heldLast));
      end
      checkVal("beat", OutBeat, expQ[idx]);
      checkVal("last", 64'(OutLast), 64'(idx == expQ.size() - 1));
      stalled  = !OutReady;
      heldBeat = OutBeat;
      heldLast = OutLast;
      if (OutReady) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    checkVal("beat_count", 64'(idx), 64'(expQ.size()));
    OutReady = 1'b0;
    @(negedge clk);
    checkVal("done_valid", 64'(OutValid), 64'd0);
    checkVal("done_ready", 64'(InBlkReady), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] q;
    logic [511:0] w;
    int idx;
    int cyc;
    rst = 1'b1;
    InBlkValid = 1'b0;
    OutReady = 1'b0;
    QuantStr = '0;
    NumValidBits = '0;
    IsOutlierArray = '0;
    InputWords = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rst_valid", 64'(OutValid), 64'd0);
    checkVal("rst_last", 64'(OutLast), 64'd0);
    checkVal("rst_beat", OutBeat, 64'd0);
    checkVal("rst_ready", 64'(InBlkReady), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkVal("post_rst_ready", 64'(InBlkReady), 64'd1);

    // payload only: 70 bits of ones
    q = '1;
    runBlock(16'h0000, 70, q, randBits(), 0);
    // outliers only
    w = randBits();
    w[31:0] = 32'hA0;
    w[95:64] = 32'hA2;
    w[511:480] = 32'hAF;
    runBlock(16'h8005, 0, randBits(), w, 0);
    // header only
    runBlock(16'h0000, 0, randBits(), randBits(), 0);
    // full payload under 1,0,0,1 backpressure
    runBlock(16'h0000, 496, randBits(), randBits(), 1);
    runBlock(16'hFFFF, 496, randBits(), randBits(), 1);

    // reset while payload beat 3 is on the bus
    q = randBits();
    buildModel(16'h1234, 496, q, randBits());
    @(negedge clk);
    QuantStr = q;
    NumValidBits = 9'd496;
    IsOutlierArray = 16'h1234;
    InBlkValid = 1'b1;
    @(posedge clk);
    #1;
    InBlkValid = 1'b0;
    OutReady = 1'b1;
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 50) begin
      @(negedge clk);
      if (OutValid) begin
        checkVal("pre_rst_beat", OutBeat, expQ[idx]);
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    checkVal("pre_rst_count", 64'(idx), 64'd4);
    rst = 1'b1;
    @(negedge clk);
    checkVal("pay3_beat", OutBeat, expQ[4]);
    @(posedge clk);
    #1;
    OutReady = 1'b0;
    @(negedge clk);
    checkVal("midrst_valid", 64'(OutValid), 64'd0);
    checkVal("midrst_ready", 64'(InBlkReady), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    runBlock(16'h0101, 130, randBits(), randBits(), 0);

    for (int b = 0; b < 40; b++) begin
      logic [15:0] m;
      int n;
      m = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
      n = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 496));
      runBlock(m, n, randBits(), randBits(), b % 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
